alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-port shared ALU with round-robin arbitration and a shared accumulator.
// Each transaction walks IDLE -> GRANT -> EXEC -> DONE; operands are captured when granted.
module alu_share_ctrl #(
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [3:0]       op0,
   input  logic [3:0]       op1,
   input  logic [1:0]       a0,
   input  logic [1:0]       b0,
   input  logic [1:0]       a1,
   input  logic [1:0]       b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [ACC_W-1:0] result,
   output logic             busy,
   output logic [ACC_W-1:0] acc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] OP_ACC = 4'd15;

   state_t           state_q;
   logic             ptr_q;
   logic             win_d;
   logic             win_q;
   logic             start_d;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             done0_q;
   logic             done1_q;
   logic             busy_q;
   logic [ACC_W-1:0] result_q;
   logic [ACC_W-1:0] acc_q;
   logic [3:0]       op_q;
   logic [1:0]       a_q;
   logic [1:0]       b_q;
   logic [ACC_W-1:0] acc_sum_d;
   logic [ACC_W-1:0] res_d;

   // Two-bit operations; opcode 15 is handled by the accumulator path.
   function automatic logic [4:0] alu_op(input logic [3:0] op,
                                         input logic [1:0] a,
                                         input logic [1:0] b);
      logic [4:0] r;
      r = 5'd0;
      case (op)
         4'd0:    r = {3'b000, a & b};
         4'd1:    r = {3'b000, a | b};
         4'd2:    r = {1'b0, ~a, ~b};
         4'd3:    r = {3'b000, a ^ b};
         4'd4:    r = {3'b000, ~(a & b)};
         4'd5:    r = {3'b000, ~(a | b)};
         4'd6:    r = {3'b000, ~(a ^ b)};
         4'd7:    r = {2'b00, {1'b0, a} + {1'b0, b}};
         4'd8:    r = {1'b0, {2'b00, a} - {2'b00, b}};
         4'd9:    r = {1'b0, {2'b00, a} * {2'b00, b}};
         4'd10:   r = (a > b) ? 5'd2 : ((a < b) ? 5'd1 : 5'd3);
         4'd11,
         4'd13:   r = {a, b, 1'b0};
         4'd12:   r = {2'b00, a, b[1]};
         4'd14:   r = {1'b0, a[1], a, b[1]};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   // A lone request wins outright; contention is settled by the pointer.
   always_comb begin
      start_d = req0 | req1;
      win_d   = ptr_q;
      if (req0 && !req1) begin
         win_d = 1'b0;
      end else if (req1 && !req0) begin
         win_d = 1'b1;
      end
   end

   always_comb begin
      acc_sum_d = acc_q + {{(ACC_W-4){1'b0}}, a_q, b_q};
      if (op_q == OP_ACC) begin
         res_d = acc_sum_d;
      end else begin
         res_d = {{(ACC_W-5){1'b0}}, alu_op(op_q, a_q, b_q)};
      end
   end

   // Operand capture needs no reset: it is only consumed after a grant.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start_d) begin
         op_q <= win_d ? op1 : op0;
         a_q  <= win_d ? a1  : a0;
         b_q  <= win_d ? b1  : b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         win_q    <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
         acc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_d) begin
                  state_q <= GRANT;
                  win_q   <= win_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  busy_q  <= 1'b1;
                  ptr_q   <= ~win_d;
               end
            end
            GRANT: begin
               state_q <= EXEC;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
            end
            EXEC: begin
               state_q  <= DONE;
               result_q <= res_d;
               done0_q  <= ~win_q;
               done1_q  <= win_q;
               if (op_q == OP_ACC) begin
                  acc_q <= acc_sum_d;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               done0_q  <= 1'b0;
               done1_q  <= 1'b0;
               busy_q   <= 1'b0;
               result_q <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign result = result_q;
   assign busy   = busy_q;
   assign acc    = acc_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table, directed multi-cycle sequences and
// randomized contention checked against an arithmetic reference model.
module tb_alu_share_ctrl;

   localparam int ACC_W = 8;

   logic             clk;
   logic             rst;
   logic             req0, req1;
   logic [3:0]       op0, op1;
   logic [1:0]       a0, b0, a1, b1;
   logic             gnt0, gnt1, done0, done1, busy;
   logic [ACC_W-1:0] result, acc;

   int n_chk  = 0;
   int n_fail = 0;
   int m_acc  = 0;
   int m_ptr  = 0;

   typedef struct {
      int         port;
      logic [3:0] op;
      logic [1:0] a;
      logic [1:0] b;
      int         exp;
   } vec_t;

   vec_t tbl[18];

   alu_share_ctrl #(.ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .result(result), .busy(busy), .acc(acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference behaviour written from the opcode definitions with integer arithmetic.
   function automatic int ref_alu(input int op, input int a, input int b);
      int x;
      x = a * 4 + b;
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return (3 - a) * 4 + (3 - b);
         3:       return a ^ b;
         4:       return 3 - (a & b);
         5:       return 3 - (a | b);
         6:       return 3 - (a ^ b);
         7:       return a + b;
         8:       return (a - b + 16) % 16;
         9:       return a * b;
         10:      return (a > b) ? 2 : ((a < b) ? 1 : 3);
         11, 13:  return x * 2;
         12:      return x / 2;
         14:      return x / 2 + ((x >= 8) ? 8 : 0);
         default: return 0;
      endcase
   endfunction

   task automatic scramble();
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      a0  = 2'($urandom_range(0, 3));
      b0  = 2'($urandom_range(0, 3));
      a1  = 2'($urandom_range(0, 3));
      b1  = 2'($urandom_range(0, 3));
   endtask

   // Single-port transaction; the request is dropped right after the grant.
   task automatic txn(input int port, input logic [3:0] op, input logic [1:0] a,
                      input logic [1:0] b, input int exp, input string tag);
      req0 = (port == 0);
      req1 = (port == 1);
      if (port == 0) begin
         op0 = op; a0 = a; b0 = b;
      end else begin
         op1 = op; a1 = a; b1 = b;
      end
      tick();
      check({tag, " gnt0"}, 32'(gnt0), 32'(port == 0));
      check({tag, " gnt1"}, 32'(gnt1), 32'(port == 1));
      check({tag, " busy"}, 32'(busy), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      scramble();
      tick();
      check({tag, " exec gnt"}, 32'({gnt0, gnt1}), 32'd0);
      check({tag, " exec done"}, 32'({done0, done1}), 32'd0);
      tick();
      check({tag, " done0"}, 32'(done0), 32'(port == 0));
      check({tag, " done1"}, 32'(done1), 32'(port == 1));
      check({tag, " result"}, 32'(result), 32'(exp));
      tick();
      check({tag, " idle"}, 32'({done0, done1, busy}), 32'd0);
      check({tag, " idle result"}, 32'(result), 32'd0);
      m_ptr = 1 - port;
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      op0 = 4'd0; op1 = 4'd0;
      a0 = 2'd0; b0 = 2'd0; a1 = 2'd0; b1 = 2'd0;

      tbl[0]  = '{0, 4'd7,  2'd3, 2'd2, 5};
      tbl[1]  = '{1, 4'd14, 2'd2, 2'd0, 12};
      tbl[2]  = '{0, 4'd10, 2'd1, 2'd1, 3};
      tbl[3]  = '{1, 4'd2,  2'd0, 2'd3, 12};
      tbl[4]  = '{0, 4'd0,  2'd3, 2'd2, 2};
      tbl[5]  = '{1, 4'd1,  2'd1, 2'd2, 3};
      tbl[6]  = '{0, 4'd3,  2'd3, 2'd1, 2};
      tbl[7]  = '{1, 4'd4,  2'd3, 2'd3, 0};
      tbl[8]  = '{0, 4'd5,  2'd0, 2'd0, 3};
      tbl[9]  = '{1, 4'd6,  2'd2, 2'd1, 0};
      tbl[10] = '{0, 4'd8,  2'd1, 2'd2, 15};
      tbl[11] = '{1, 4'd9,  2'd3, 2'd3, 9};
      tbl[12] = '{0, 4'd11, 2'd3, 2'd3, 30};
      tbl[13] = '{1, 4'd13, 2'd2, 2'd1, 18};
      tbl[14] = '{0, 4'd12, 2'd3, 2'd2, 7};
      tbl[15] = '{1, 4'd10, 2'd3, 2'd1, 2};
      tbl[16] = '{0, 4'd10, 2'd0, 2'd2, 1};
      tbl[17] = '{1, 4'd14, 2'd0, 2'd3, 1};

      // Reset state
      tick();
      tick();
      check("rst gnt", 32'({gnt0, gnt1}), 32'd0);
      check("rst done", 32'({done0, done1}), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst acc", 32'(acc), 32'd0);
      rst = 1'b0;
      tick();
      check("idle no req", 32'({busy, gnt0, gnt1}), 32'd0);

      // Contention straight after reset: port 0 first, then port 1
      req0 = 1'b1; op0 = 4'd9; a0 = 2'd3; b0 = 2'd3;
      req1 = 1'b1; op1 = 4'd8; a1 = 2'd1; b1 = 2'd2;
      tick();
      check("cont gnt0", 32'({gnt0, gnt1}), 32'b10);
      tick();
      check("cont exec gnt", 32'({gnt0, gnt1}), 32'd0);
      tick();
      check("cont done0", 32'({done0, done1}), 32'b10);
      check("cont result0", 32'(result), 32'd9);
      tick();
      check("cont gap", 32'({gnt0, gnt1, busy}), 32'd0);
      tick();
      check("cont gnt1", 32'({gnt0, gnt1}), 32'b01);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();
      check("cont done1", 32'({done0, done1}), 32'b01);
      check("cont result1", 32'(result), 32'd15);
      tick();
      m_ptr = 0;

      foreach (tbl[i]) begin
         txn(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // No second grant after a dropped request
      tick();
      check("drop no regrant", 32'({gnt0, gnt1, busy}), 32'd0);

      // Shared accumulator wraps modulo 2^ACC_W
      for (int k = 0; k < 18; k++) begin
         m_acc = (m_acc + 15) % (1 << ACC_W);
         txn(1, 4'd15, 2'd3, 2'd3, m_acc, $sformatf("accum%0d", k));
      end
      check("accum final", 32'(acc), 32'd14);

      // Randomized traffic with contention and noisy inputs while busy
      for (int it = 0; it < 300; it++) begin
         int r0, r1, win, wop, wa, wb, exp;
         r0 = int'($urandom_range(0, 1));
         r1 = int'($urandom_range(0, 1));
         scramble();
         req0 = r0[0];
         req1 = r1[0];
         if (r0 == 0 && r1 == 0) begin
            tick();
            check("rand idle", 32'({gnt0, gnt1, busy}), 32'd0);
            continue;
         end
         win = (r0 == 1 && r1 == 1) ? m_ptr : ((r1 == 1) ? 1 : 0);
         m_ptr = 1 - win;
         wop = (win == 0) ? int'(op0) : int'(op1);
         wa  = (win == 0) ? int'(a0)  : int'(a1);
         wb  = (win == 0) ? int'(b0)  : int'(b1);
         if (wop == 15) begin
            m_acc = (m_acc + wa * 4 + wb) % (1 << ACC_W);
            exp = m_acc;
         end else begin
            exp = ref_alu(wop, wa, wb);
         end
         tick();
         check("rand gnt", 32'({gnt0, gnt1}), (win == 0) ? 32'b10 : 32'b01);
         scramble();
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         tick();
         check("rand exec", 32'({gnt0, gnt1, done0, done1}), 32'd0);
         scramble();
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         tick();
         check("rand done", 32'({done0, done1}), (win == 0) ? 32'b10 : 32'b01);
         check("rand result", 32'(result), 32'(exp));
         check("rand acc", 32'(acc), 32'(m_acc));
         req0 = 1'b0;
         req1 = 1'b0;
         tick();
         check("rand idle out", 32'({done0, done1, busy}), 32'd0);
      end

      // Reset during EXEC after two accumulations
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_acc = 0;
      m_ptr = 0;
      txn(0, 4'd15, 2'd0, 2'd1, 1, "racc0");
      txn(0, 4'd15, 2'd0, 2'd1, 2, "racc1");
      check("racc acc", 32'(acc), 32'd2);
      req0 = 1'b1; op0 = 4'd15; a0 = 2'd3; b0 = 2'd3;
      tick();
      req0 = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("rst exec busy", 32'(busy), 32'd0);
      check("rst exec acc", 32'(acc), 32'd0);
      tick();
      check("rst exec done", 32'({done0, done1}), 32'd0);
      check("rst exec result", 32'(result), 32'd0);
      rst = 1'b0;
      req0 = 1'b1; op0 = 4'd7; a0 = 2'd1; b0 = 2'd1;
      req1 = 1'b1; op1 = 4'd9; a1 = 2'd2; b1 = 2'd2;
      tick();
      check("post rst gnt", 32'({gnt0, gnt1}), 32'b10);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();
      check("post rst done", 32'({done0, done1}), 32'b10);
      check("post rst result", 32'(result), 32'd2);
      check("post rst acc", 32'(acc), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
